// File: rtl/id_ex_stage.sv
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID/EX pipeline register with MEM/WB operand forwarding,
//             WB write-through and single-bubble load-use hazard handling.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          ext_stall,
   input  logic          id_valid,
   input  logic [5:0]    id_alu_op,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic          id_b_is_imm,
   input  logic [DW-1:0] id_imm,
   input  logic [4:0]    id_shamt,
   input  logic [4:0]    id_ins15_11,
   input  logic [RW-1:0] id_dest,
   input  logic          id_reg_write,
   input  logic          id_mem_read,
   input  logic          mem_reg_write,
   input  logic [RW-1:0] mem_dest,
   input  logic [DW-1:0] mem_data,
   input  logic          wb_reg_write,
   input  logic [RW-1:0] wb_dest,
   input  logic [DW-1:0] wb_data,
   output logic          ex_valid,
   output logic [5:0]    ex_alu_op,
   output logic [DW-1:0] ex_a,
   output logic [DW-1:0] ex_b,
   output logic [4:0]    ex_shamt,
   output logic [4:0]    ex_ins15_11,
   output logic [RW-1:0] ex_dest,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic          load_use_stall
);

   logic          r_valid;
   logic [5:0]    r_alu_op;
   logic [RW-1:0] r_rs;
   logic [RW-1:0] r_rt;
   logic [DW-1:0] r_rs_val;
   logic [DW-1:0] r_rt_val;
   logic          r_b_is_imm;
   logic [DW-1:0] r_imm;
   logic [4:0]    r_shamt;
   logic [4:0]    r_ins15_11;
   logic [RW-1:0] r_dest;
   logic          r_reg_write;
   logic          r_mem_read;

   logic          w_load_use;
   logic [DW-1:0] w_rs_in;
   logic [DW-1:0] w_rt_in;
   logic [DW-1:0] w_a;
   logic [DW-1:0] w_rt_fwd;

   // A load in EX whose result is needed by decode cannot be forwarded yet.
   assign w_load_use = !flush && r_valid && r_mem_read && (r_dest != '0) && id_valid &&
                       ((id_rs == r_dest) || (!id_b_is_imm && (id_rt == r_dest)));

   // WB writes the register file in the same cycle decode reads it.
   assign w_rs_in = (wb_reg_write && (wb_dest != '0) && (wb_dest == id_rs)) ? wb_data : id_rs_data;
   assign w_rt_in = (wb_reg_write && (wb_dest != '0) && (wb_dest == id_rt)) ? wb_data : id_rt_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid     <= 1'b0;
         r_alu_op    <= '0;
         r_rs        <= '0;
         r_rt        <= '0;
         r_rs_val    <= '0;
         r_rt_val    <= '0;
         r_b_is_imm  <= 1'b0;
         r_imm       <= '0;
         r_shamt     <= '0;
         r_ins15_11  <= '0;
         r_dest      <= '0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
      end else if (flush || (!ext_stall && w_load_use)) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
      end else if (!ext_stall) begin
         r_valid     <= id_valid;
         r_alu_op    <= id_alu_op;
         r_rs        <= id_rs;
         r_rt        <= id_rt;
         r_rs_val    <= w_rs_in;
         r_rt_val    <= w_rt_in;
         r_b_is_imm  <= id_b_is_imm;
         r_imm       <= id_imm;
         r_shamt     <= id_shamt;
         r_ins15_11  <= id_ins15_11;
         r_dest      <= id_dest;
         r_reg_write <= id_reg_write;
         r_mem_read  <= id_mem_read;
      end
   end

   // MEM is the younger producer, so it wins over WB.
   always_comb begin
      w_a = r_rs_val;
      if (mem_reg_write && (mem_dest != '0) && (mem_dest == r_rs))
         w_a = mem_data;
      else if (wb_reg_write && (wb_dest != '0) && (wb_dest == r_rs))
         w_a = wb_data;

      w_rt_fwd = r_rt_val;
      if (mem_reg_write && (mem_dest != '0) && (mem_dest == r_rt))
         w_rt_fwd = mem_data;
      else if (wb_reg_write && (wb_dest != '0) && (wb_dest == r_rt))
         w_rt_fwd = wb_data;
   end

   assign ex_valid       = r_valid;
   assign ex_alu_op      = r_alu_op;
   assign ex_a           = w_a;
   assign ex_b           = r_b_is_imm ? r_imm : w_rt_fwd;
   assign ex_shamt       = r_shamt;
   assign ex_ins15_11    = r_ins15_11;
   assign ex_dest        = r_dest;
   assign ex_reg_write   = r_reg_write & r_valid;
   assign ex_mem_read    = r_mem_read & r_valid;
   assign load_use_stall = w_load_use;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
//  Module   : tb_id_ex_stage
//  Purpose  : Directed scoreboard bench for id_ex_stage.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

   localparam logic [5:0] c_op_addu = 6'd1;
   localparam logic [5:0] c_op_subu = 6'd2;
   localparam logic [5:0] c_op_lw   = 6'd3;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  op;
      logic [4:0]  shamt;
      logic [4:0]  ins;
      logic [4:0]  dest;
      logic        rw;
      logic        mr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, ext_stall, id_valid;
   logic [5:0]  id_alu_op;
   logic [4:0]  id_rs, id_rt, id_shamt, id_ins15_11, id_dest;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic        id_b_is_imm, id_reg_write, id_mem_read;
   logic        mem_reg_write, wb_reg_write;
   logic [4:0]  mem_dest, wb_dest;
   logic [31:0] mem_data, wb_data;
   logic        ex_valid, ex_reg_write, ex_mem_read, load_use_stall;
   logic [5:0]  ex_alu_op;
   logic [31:0] ex_a, ex_b;
   logic [4:0]  ex_shamt, ex_ins15_11, ex_dest;

   exp_t exp_cur;
   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .ext_stall(ext_stall),
      .id_valid(id_valid), .id_alu_op(id_alu_op), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_b_is_imm(id_b_is_imm),
      .id_imm(id_imm), .id_shamt(id_shamt), .id_ins15_11(id_ins15_11),
      .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .mem_data(mem_data),
      .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_a(ex_a), .ex_b(ex_b),
      .ex_shamt(ex_shamt), .ex_ins15_11(ex_ins15_11), .ex_dest(ex_dest),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .load_use_stall(load_use_stall)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Monitor: every cycle the stage shows a valid instruction, it must match the next queued entry.
   always @(negedge clk) begin
      if (!rst && ex_valid) begin
         exp_t act;
         exp_t e;
         act = '{a: ex_a, b: ex_b, op: ex_alu_op, shamt: ex_shamt, ins: ex_ins15_11,
                 dest: ex_dest, rw: ex_reg_write, mr: ex_mem_read};
         n_checks++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got valid output %h expected none", act);
         end else begin
            e = q.pop_front();
            if (act !== e) begin
               n_fail++;
               $display("FAIL sb_compare: got a=%h b=%h all=%h expected a=%h b=%h all=%h",
                        act.a, act.b, act, e.a, e.b, e);
            end
         end
      end
   end

   task automatic idle();
      flush = 0; ext_stall = 0; id_valid = 0; id_alu_op = '0; id_rs = '0; id_rt = '0;
      id_rs_data = '0; id_rt_data = '0; id_b_is_imm = 0; id_imm = '0; id_shamt = '0;
      id_ins15_11 = '0; id_dest = '0; id_reg_write = 0; id_mem_read = 0;
      mem_reg_write = 0; mem_dest = '0; mem_data = '0;
      wb_reg_write = 0; wb_dest = '0; wb_data = '0;
   endtask

   task automatic issue(input logic upd, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic bimm, input logic [31:0] imm, input logic [4:0] dest,
                        input logic rw, input logic mr);
      id_valid = 1; id_alu_op = op; id_rs = rs; id_rt = rt; id_rs_data = rsd;
      id_rt_data = rtd; id_b_is_imm = bimm; id_imm = imm; id_shamt = rs;
      id_ins15_11 = rt; id_dest = dest; id_reg_write = rw; id_mem_read = mr;
      if (upd) begin
         exp_cur.op = op; exp_cur.shamt = rs; exp_cur.ins = rt;
         exp_cur.dest = dest; exp_cur.rw = rw; exp_cur.mr = mr;
      end
   endtask

   // Inputs are already driven; check the stall flag, queue what the next negedge must show.
   task automatic tick(input logic lus, input logic vld);
      #1;
      chk("load_use_stall", {31'b0, load_use_stall}, {31'b0, lus});
      if (vld) q.push_back(exp_cur);
      @(negedge clk);
      #1;
      chk("ex_valid", {31'b0, ex_valid}, {31'b0, vld});
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, {31'b0, ex_valid}, 32'd0);
      chk({tag, "_op"},    {26'b0, ex_alu_op}, 32'd0);
      chk({tag, "_dest"},  {27'b0, ex_dest}, 32'd0);
      chk({tag, "_rw_mr"}, {30'b0, ex_reg_write, ex_mem_read}, 32'd0);
      chk({tag, "_a_b"},   ex_a | ex_b, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      exp_cur = '0;
      rst = 1;
      idle();
      #2;
      chk_zero("reset");
      @(negedge clk); #1;
      rst = 0;

      // EX->EX forward: SUBU reads r3 while ADDU's result sits in MEM
      issue(1, c_op_addu, 5'd1, 5'd2, 32'h5, 32'h6, 0, 32'h0, 5'd3, 1, 0);
      exp_cur.a = 32'h5; exp_cur.b = 32'h6; tick(0, 1);
      issue(1, c_op_subu, 5'd3, 5'd1, 32'h99, 32'h5, 0, 32'h0, 5'd4, 1, 0);
      mem_reg_write = 1; mem_dest = 5'd3; mem_data = 32'h10;
      exp_cur.a = 32'h10; exp_cur.b = 32'h5; tick(0, 1);

      // MEM beats WB; r0 never forwards; WB alone forwards
      issue(1, c_op_addu, 5'd5, 5'd0, 32'h7, 32'h0, 0, 32'h0, 5'd6, 1, 0);
      mem_dest = 5'd5; mem_data = 32'hA; wb_reg_write = 1; wb_dest = 5'd5; wb_data = 32'hB;
      exp_cur.a = 32'hA; exp_cur.b = 32'h0; tick(0, 1);
      issue(1, c_op_addu, 5'd0, 5'd0, 32'h7, 32'h3, 0, 32'h0, 5'd6, 1, 0);
      mem_dest = 5'd0; wb_dest = 5'd0;
      exp_cur.a = 32'h7; exp_cur.b = 32'h3; tick(0, 1);
      issue(1, c_op_addu, 5'd5, 5'd5, 32'h7, 32'h8, 1, 32'h1234, 5'd6, 1, 0);
      mem_reg_write = 0; wb_dest = 5'd5;
      exp_cur.a = 32'hB; exp_cur.b = 32'h1234; tick(0, 1);
      idle();

      // Load-use on rs: one bubble, then the re-presented op latches
      issue(1, c_op_lw, 5'd1, 5'd2, 32'h100, 32'h0, 1, 32'h4, 5'd2, 1, 1);
      exp_cur.a = 32'h100; exp_cur.b = 32'h4; tick(0, 1);
      issue(1, c_op_addu, 5'd2, 5'd3, 32'h0, 32'h8, 0, 32'h0, 5'd5, 1, 0);
      tick(1, 0);
      mem_reg_write = 1; mem_dest = 5'd2; mem_data = 32'h55;
      exp_cur.a = 32'h55; exp_cur.b = 32'h8; tick(0, 1);
      mem_reg_write = 0;
      // Immediate operand hides the rt match
      issue(1, c_op_lw, 5'd1, 5'd2, 32'h100, 32'h0, 1, 32'h4, 5'd2, 1, 1);
      exp_cur.a = 32'h100; exp_cur.b = 32'h4; tick(0, 1);
      issue(1, c_op_addu, 5'd3, 5'd2, 32'h8, 32'h0, 1, 32'h10, 5'd6, 1, 0);
      exp_cur.a = 32'h8; exp_cur.b = 32'h10; tick(0, 1);
      // Load-use on rt
      issue(1, c_op_lw, 5'd1, 5'd2, 32'h100, 32'h0, 1, 32'h4, 5'd2, 1, 1);
      exp_cur.a = 32'h100; exp_cur.b = 32'h4; tick(0, 1);
      issue(1, c_op_addu, 5'd3, 5'd2, 32'h8, 32'h0, 0, 32'h0, 5'd5, 1, 0);
      tick(1, 0);
      mem_reg_write = 1; mem_dest = 5'd2; mem_data = 32'h66;
      exp_cur.a = 32'h8; exp_cur.b = 32'h66; tick(0, 1);
      mem_reg_write = 0;

      // Stall holds for 3 cycles with forwarding still live, then flush under stall
      issue(1, c_op_addu, 5'd1, 5'd3, 32'h11, 32'h22, 0, 32'h0, 5'd7, 1, 0);
      exp_cur.a = 32'h11; exp_cur.b = 32'h22; tick(0, 1);
      ext_stall = 1;
      issue(0, c_op_subu, 5'd4, 5'd5, 32'hEE, 32'hEF, 0, 32'h0, 5'd9, 1, 0);
      tick(0, 1);
      tick(0, 1);
      mem_reg_write = 1; mem_dest = 5'd1; mem_data = 32'h77;
      exp_cur.a = 32'h77; tick(0, 1);
      mem_reg_write = 0; flush = 1;
      tick(0, 0);
      flush = 0; ext_stall = 0;

      // Flush masks a load-use hazard
      issue(1, c_op_lw, 5'd1, 5'd2, 32'h100, 32'h0, 1, 32'h4, 5'd2, 1, 1);
      exp_cur.a = 32'h100; exp_cur.b = 32'h4; tick(0, 1);
      issue(1, c_op_addu, 5'd2, 5'd3, 32'h9, 32'h8, 0, 32'h0, 5'd5, 1, 0);
      flush = 1; tick(0, 0);
      flush = 0;
      exp_cur.a = 32'h9; exp_cur.b = 32'h8; tick(0, 1);

      // Write-through: the held value must be WB's data after WB goes away
      issue(1, c_op_addu, 5'd7, 5'd0, 32'h0, 32'h0, 0, 32'h0, 5'd8, 1, 0);
      wb_reg_write = 1; wb_dest = 5'd7; wb_data = 32'hDEAD;
      exp_cur.a = 32'hDEAD; exp_cur.b = 32'h0; tick(0, 1);
      wb_reg_write = 0; ext_stall = 1;
      tick(0, 1);

      // Asynchronous reset mid-cycle with a valid op held
      #1 rst = 1;
      #1 chk_zero("async_rst");
      idle();
      #1 rst = 0;
      @(negedge clk); #1;
      chk("post_rst_valid", {31'b0, ex_valid}, 32'd0);
      tick(0, 0);
      chk("sb_drained", q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
